// File: rtl/thermo_decoder.sv
// thermo_decoder
//   Receiving end of the thermometer-code path. It decodes a 15-bit
//   thermometer word (value N is carried as bits [N-1:0] set) back into a
//   4-bit binary count.
//   Pipeline: stage 1 registers the word's popcount and its legality.
//   Stage 2 registers the outputs. Valid input is 2 cycles from valid output.
//   An illegal (bubbled) word is flagged on code_err. It is also counted in
//   a saturating error counter and latched in a sticky flag. Its count
//   repeats the last good value.
//
//   Optional build macro THERMO_BUBBLE_CORRECT_EN:
//     defined   - an illegal word is corrected to its popcount, and
//                 last-good follows that popcount. The error flagging is
//                 unchanged.
//     undefined - an illegal word repeats the last good count.
//
// Parameters
//   ERR_CNT_W   width of the saturating invalid-code counter (1..16)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   thermo_in   15-bit thermometer word
//   valid_in    thermo_in qualifier, sampled every cycle
//   clear_err   synchronous clear of err_sticky / err_count
//   count       decoded binary count (held while valid_out=0)
//   valid_out   one pulse per accepted input, 2 cycles later
//   code_err    current output came from an illegal word (with valid_out)
//   err_sticky  any illegal word since last clear/reset
//   err_count   number of illegal words, saturating at all-ones
module thermo_decoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [14:0]          thermo_in,
   input  logic                 valid_in,
   input  logic                 clear_err,
   output logic [3:0]           count,
   output logic                 valid_out,
   output logic                 code_err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int STAGES = 2;

   // Stage-1 payload. The qualifier travels separately in vld_pipe.
   typedef struct packed {
      logic [3:0] ones;
      logic       legal;
   } s1_t;

   function automatic logic [3:0] popcnt15(input logic [14:0] v);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 15; i++) s = s + {3'b000, v[i]};
      return s;
   endfunction

   logic [STAGES-1:0] vld_pipe;   // [0]: stage-1 valid, [1]: output valid
   s1_t               s1_q;
   s1_t               s1_d;
   logic [3:0]        in_ones;
   logic [3:0]        last_good;
   logic [3:0]        bad_count;
   logic              err_hit;

   // A legal word is a run of ones from bit 0. The all-ones word shifted
   // left by the popcount leaves zeros exactly where those ones should be.
   // For ones=15 the shift empties the word, so its complement is 7FFF.
   always_comb begin
      in_ones     = popcnt15(thermo_in);
      s1_d        = '0;
      s1_d.ones   = in_ones;
      s1_d.legal  = (thermo_in == ~(15'h7FFF << in_ones));
   end

   // Value presented for an illegal word.
`ifdef THERMO_BUBBLE_CORRECT_EN
   assign bad_count = s1_q.ones;
`else
   assign bad_count = last_good;
`endif

   assign err_hit = vld_pipe[0] & ~s1_q.legal;

   // Stage 1 and valid pipeline
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_pipe <= '0;
         s1_q     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-2:0], valid_in};
         s1_q     <= s1_d;
      end
   end

   assign valid_out = vld_pipe[STAGES-1];

   // Stage 2: decoded outputs and last-good tracking
   always_ff @(posedge clk) begin
      if (!reset) begin
         count     <= '0;
         code_err  <= 1'b0;
         last_good <= '0;
      end else if (vld_pipe[0]) begin
         if (s1_q.legal) begin
            count     <= s1_q.ones;
            code_err  <= 1'b0;
            last_good <= s1_q.ones;
         end else begin
            count     <= bad_count;
            code_err  <= 1'b1;
            last_good <= bad_count;
         end
      end else begin
         code_err <= 1'b0;          // count holds across bubbles
      end
   end

   // Error accounting. A clear and a coincident error leave a count of one:
   // the clear is applied first, then the new error is counted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (clear_err) begin
         err_sticky <= err_hit;
         err_count  <= err_hit ? ERR_CNT_W'(1) : '0;
      end else if (err_hit) begin
         err_sticky <= 1'b1;
         if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_thermo_decoder.sv
// Directed bench for thermo_decoder (ERR_CNT_W=2 so saturation is reachable).
// Inputs are driven 1 time unit after a rising edge. Outputs are checked at
// the same point, so they show the result of the edge just passed.
module tb_thermo_decoder;

   localparam int W = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [14:0]   thermo_in;
   logic          valid_in;
   logic          clear_err;
   logic [3:0]    count;
   logic          valid_out;
   logic          code_err;
   logic          err_sticky;
   logic [W-1:0]  err_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   thermo_decoder #(.ERR_CNT_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .thermo_in (thermo_in),
      .valid_in  (valid_in),
      .clear_err (clear_err),
      .count     (count),
      .valid_out (valid_out),
      .code_err  (code_err),
      .err_sticky(err_sticky),
      .err_count (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [14:0] t);
      valid_in  = v;
      thermo_in = t;
      tick();
   endtask

   function automatic logic [14:0] therm(input int n);
      logic [15:0] m;
      m = (16'd1 << n) - 16'd1;
      return m[14:0];
   endfunction

   task automatic chk_out(input string tag, input logic v, input int c, input logic e);
      chk({tag, ".valid"}, 32'(valid_out), 32'(v));
      chk({tag, ".count"}, 32'(count), c);
      chk({tag, ".cerr"},  32'(code_err), 32'(e));
   endtask

`ifdef THERMO_BUBBLE_CORRECT_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   int lg;
   int exp_sat[5] = '{1, 2, 3, 3, 3};

   initial begin
      reset = 1'b0; valid_in = 1'b1; thermo_in = 15'h7FFF; clear_err = 1'b0;
      #1;
      // Reset held with a live input stream
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rst", 1'b0, 0, 1'b0);
         chk("rst.sticky", 32'(err_sticky), 0);
         chk("rst.ecnt", 32'(err_count), 0);
      end
      reset = 1'b1;
      drive(1'b0, 15'h0); chk("rel1.valid", 32'(valid_out), 0);
      drive(1'b0, 15'h0); chk("rel2.valid", 32'(valid_out), 0);

      // Full sweep of legal codes, back-to-back
      for (int n = 0; n < 16; n++) begin
         drive(1'b1, therm(n));
         if (n > 0) chk_out($sformatf("sweep%0d", n - 1), 1'b1, n - 1, 1'b0);
      end
      drive(1'b0, 15'h0);
      chk_out("sweep15", 1'b1, 15, 1'b0);
      chk("sweep.ecnt", 32'(err_count), 0);
      drive(1'b0, 15'h0);
      chk_out("sweep.hold", 1'b0, 15, 1'b0);

      // Reset mid-stream drops the in-flight word
      drive(1'b1, therm(3));
      reset = 1'b0;
      drive(1'b0, 15'h0);
      chk_out("midrst", 1'b0, 0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 15'h0);
      chk("midrst.after", 32'(valid_out), 0);

      // Bubble: 5 then an illegal word 0x5F (popcount 6)
      drive(1'b1, 15'h001F);
      drive(1'b1, 15'h005F);
      chk_out("bub.first", 1'b1, 5, 1'b0);
      drive(1'b0, 15'h0);
      chk_out("bub.bad", 1'b1, CORR ? 6 : 5, 1'b1);
      chk("bub.sticky", 32'(err_sticky), 1);
      chk("bub.ecnt", 32'(err_count), 1);
      drive(1'b0, 15'h0);
      chk_out("bub.idle", 1'b0, CORR ? 6 : 5, 1'b0);

      // Gapped stream 3, bubble, 9
      drive(1'b1, therm(3));
      drive(1'b0, 15'h7FFF);
      chk_out("gap.a", 1'b1, 3, 1'b0);
      drive(1'b1, therm(9));
      chk_out("gap.b", 1'b0, 3, 1'b0);
      drive(1'b0, 15'h0);
      chk_out("gap.c", 1'b1, 9, 1'b0);
      lg = 9;

      // Clear with no error in flight
      clear_err = 1'b1;
      drive(1'b0, 15'h0);
      clear_err = 1'b0;
      chk("clr.sticky", 32'(err_sticky), 0);
      chk("clr.ecnt", 32'(err_count), 0);

      // Five consecutive illegal words (0x0002, popcount 1) saturate a 2-bit counter
      drive(1'b1, 15'h0002);
      for (int i = 0; i < 5; i++) begin
         drive(i < 4, 15'h0002);
         chk_out($sformatf("sat%0d", i), 1'b1, CORR ? 1 : lg, 1'b1);
         chk($sformatf("sat%0d.ecnt", i), 32'(err_count), exp_sat[i]);
      end
      if (CORR) lg = 1;

      // A clear that coincides with an error leaves the count at 1
      drive(1'b1, 15'h0002);
      chk("col.pre", 32'(err_count), 3);
      clear_err = 1'b1;
      drive(1'b0, 15'h0);
      chk_out("col", 1'b1, CORR ? 1 : lg, 1'b1);
      chk("col.ecnt", 32'(err_count), 1);
      chk("col.sticky", 32'(err_sticky), 1);
      drive(1'b0, 15'h0);
      clear_err = 1'b0;
      chk("col2.ecnt", 32'(err_count), 0);
      chk("col2.sticky", 32'(err_sticky), 0);
      chk("col2.cerr", 32'(code_err), 0);

      // A clear leaves last-good intact: an illegal word still repeats it
      drive(1'b1, 15'h0005);   // popcount 2, illegal
      drive(1'b0, 15'h0);
      chk_out("lg.keep", 1'b1, CORR ? 2 : lg, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
